ddr2_sys_st_byte_arbiter: RTL and testbench
===========================================

DDR2_SYS_ST_BYTE_ARBITER -- requirements
Module: ddr2_sys_st_byte_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width of every data port.
REQ-002 Parameter RR_FIRST, default 0, SHALL select which input wins the first tie after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset, asynchronous assertion, active-low.
REQ-005 in0_valid, in0_sop, in0_eop  input  1 each  SHALL carry requester 0 beat valid, start-of-packet and end-of-packet.
REQ-006 in0_data  input  DATA_W  SHALL carry requester 0 payload.
REQ-007 in0_ready  output  1  SHALL be requester 0 backpressure.
REQ-008 in1_valid, in1_sop, in1_eop, in1_data, in1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 out_valid, out_sop, out_eop  output  1 each  SHALL be the shared stream beat qualifiers.
REQ-010 out_data  output  DATA_W  SHALL be the shared stream payload.
REQ-011 out_ready  input  1  SHALL be downstream backpressure.
REQ-012 busy  output  1  SHALL be high whenever a packet lock is held.
REQ-013 out_channel  output  1  SHALL be present only when the REQ-030 macro is defined.

Function
REQ-014 FSM states SHALL be IDLE, LOCK0, LOCK1; busy = (state != IDLE).
REQ-015 In IDLE, the winner SHALL be the sole valid input, or on a tie the input not most recently granted (last_grant).
REQ-016 The output stage SHALL be one register (data, sop, eop, valid); load_ok = !out_valid | out_ready.
REQ-017 inX_ready SHALL equal load_ok AND (X is the winner in IDLE, or state == LOCKX); the non-selected input's ready SHALL be 0.
REQ-018 A beat accepted on input X (inX_valid & inX_ready) SHALL appear on the output register the next cycle, giving latency 1.
REQ-019 An accepted beat in IDLE without eop SHALL move the FSM to LOCKX and set last_grant = X.
REQ-020 An accepted beat in IDLE with eop (single-beat packet) SHALL keep the FSM in IDLE and set last_grant = X.
REQ-021 An accepted beat with eop in LOCKX SHALL return the FSM to IDLE, leaving exactly one arbitration cycle before any further beat.
REQ-022 A beat without sop SHALL be accepted as a packet start; sop/eop SHALL pass through unmodified.
REQ-023 While out_valid & !out_ready, the output register SHALL hold and both readies SHALL be 0.
REQ-024 If out_ready is high and no beat is accepted, out_valid SHALL clear the next cycle.
REQ-025 In LOCKX, requests from the other input SHALL be ignored until eop is accepted.

Reset
REQ-026 On reset_n low: state = IDLE, out_valid = 0, out_sop = 0, out_eop = 0, out_data = 0, last_grant = !RR_FIRST, busy = 0; out_channel = 0 if present.
REQ-027 Reset mid-packet SHALL discard the lock and any staged beat, with no partial eop emitted.
REQ-028 in0_ready and in1_ready SHALL both be 0 while reset_n is low.
REQ-029 The first edge after deassertion SHALL arbitrate normally.

Configuration
REQ-030 With DDR2_SYS_ST_ARB_CHANNEL_EN defined, out_channel SHALL be registered alongside out_data and carry the source index of each output beat.
REQ-031 Without DDR2_SYS_ST_ARB_CHANNEL_EN, the out_channel port and its register SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Both idle after reset, then in0 sends a 3-beat packet 0x11/0x22/0x33 with out_ready=1 -> out beats 0x11(sop), 0x22, 0x33(eop) one cycle after each accept; busy high for 2 cycles.
REQ-033 Both inputs request in the same IDLE cycle with RR_FIRST=0 -> in0 packet is output first, then in1 after one idle arbitration cycle; repeating the tie -> in1 wins.
REQ-034 in1 holds lock mid-packet while in0 asserts valid -> in0_ready stays 0 until in1 eop is accepted.
REQ-035 out_ready held low for 4 cycles mid-packet -> output register holds 0x22, both readies 0, no beat lost or duplicated after out_ready returns.
REQ-036 reset_n pulsed low during beat 2 of a 4-beat packet -> out_valid=0 and busy=0 immediately; next packet starts cleanly with sop.
REQ-037 With DDR2_SYS_ST_ARB_CHANNEL_EN defined, alternating single-beat packets sop=eop=1 from in0=0xA5 and in1=0x5A -> out_channel toggles 0,1,0,1 matching the data.

Source files
------------

// File: rtl/ddr2_sys_st_byte_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddr2_sys_st_byte_arbiter_if
// Purpose  : Bundle of streaming signals for the two-input packet arbiter.
//            Requester 0 and 1 each present valid/sop/eop/data and receive
//            ready; the shared output stream presents valid/sop/eop/data and
//            receives ready. busy reports a held packet lock.
// Ports    : (interface signals)
//            in0_valid, in0_sop, in0_eop, in0_data, in0_ready  requester 0
//            in1_valid, in1_sop, in1_eop, in1_data, in1_ready  requester 1
//            out_valid, out_sop, out_eop, out_data, out_ready  shared stream
//            busy                                             lock held
//            out_channel  source index of output beat, present only when
//                         DDR2_SYS_ST_ARB_CHANNEL_EN is defined
// Modports : slave  - the arbiter itself
//            master - the surrounding environment (requesters + sink)
// Revision : 1.0 - initial release
// ============================================================================
interface ddr2_sys_st_byte_arbiter_if #(
  parameter int DATA_W = 8
);
  // Requester 0
  logic              in0_valid;
  logic              in0_sop;
  logic              in0_eop;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  // Requester 1
  logic              in1_valid;
  logic              in1_sop;
  logic              in1_eop;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  // Shared output stream
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
  logic              out_channel;
`endif

  modport slave (
    input  in0_valid, in0_sop, in0_eop, in0_data,
    output in0_ready,
    input  in1_valid, in1_sop, in1_eop, in1_data,
    output in1_ready,
    output out_valid, out_sop, out_eop, out_data,
    input  out_ready,
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
    output out_channel,
`endif
    output busy
  );

  modport master (
    output in0_valid, in0_sop, in0_eop, in0_data,
    input  in0_ready,
    output in1_valid, in1_sop, in1_eop, in1_data,
    input  in1_ready,
    input  out_valid, out_sop, out_eop, out_data,
    output out_ready,
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
    input  out_channel,
`endif
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/ddr2_sys_st_byte_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddr2_sys_st_byte_arbiter
// Purpose  : Two-input packet arbiter for a byte-wide streaming bus. Once a
//            requester wins with a non-eop beat it owns the output until its
//            eop beat is accepted. Ties in the idle state go to the requester
//            that was not granted most recently. A single output register
//            gives one cycle of latency from accept to output.
// Params   : DATA_W   - payload width of every data port
//            RR_FIRST - requester that wins the first tie after reset
// Ports    : clk      - single clock, rising edge
//            reset_n  - asynchronous active-low reset
//            bus      - ddr2_sys_st_byte_arbiter_if.slave (both requesters,
//                       shared output stream, busy, optional out_channel)
// Options  : DDR2_SYS_ST_ARB_CHANNEL_EN - when defined, out_channel is
//            registered alongside out_data and carries the source index.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_sys_st_byte_arbiter #(
  parameter int DATA_W   = 8,
  parameter int RR_FIRST = 0
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  ddr2_sys_st_byte_arbiter_if.slave     bus
);

  // last_grant holds the index of the most recently granted requester. It
  // resets to the opposite of RR_FIRST so the first tie goes to RR_FIRST.
  localparam logic LAST_GRANT_RST = (RR_FIRST == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;

  // Output stage register
  logic              out_valid_q;
  logic              out_sop_q;
  logic              out_eop_q;
  logic [DATA_W-1:0] out_data_q;
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
  logic              out_channel_q;
`endif

  // Arbitration / handshake terms
  logic              load_ok;
  logic              win0;
  logic              win1;
  logic              rdy0;
  logic              rdy1;
  logic              acc0;
  logic              acc1;

  always_comb begin
    load_ok = !out_valid_q || bus.out_ready;

    // Winner selection only applies in IDLE; a locked state ignores the
    // other requester entirely.
    win0 = 1'b0;
    win1 = 1'b0;
    if (state == IDLE) begin
      if (bus.in0_valid && bus.in1_valid) begin
        // Tie: favour the requester that did not win last time.
        win0 = last_grant;
        win1 = !last_grant;
      end else begin
        win0 = bus.in0_valid;
        win1 = bus.in1_valid;
      end
    end

    // Gating with reset_n keeps both readies low while reset is asserted,
    // even though the reset state would otherwise allow a load.
    rdy0 = reset_n && load_ok && (win0 || (state == LOCK0));
    rdy1 = reset_n && load_ok && (win1 || (state == LOCK1));

    acc0 = bus.in0_valid && rdy0;
    acc1 = bus.in1_valid && rdy1;
  end

  assign bus.in0_ready = rdy0;
  assign bus.in1_ready = rdy1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state != IDLE);
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
  assign bus.out_channel = out_channel_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= LAST_GRANT_RST;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
      out_channel_q <= 1'b0;
`endif
    end else begin
      // Output stage: load an accepted beat, otherwise drain when the sink
      // takes the current beat. When stalled nothing is accepted, so the
      // register simply holds.
      if (acc0 || acc1) begin
        out_valid_q <= 1'b1;
        out_sop_q   <= acc1 ? bus.in1_sop  : bus.in0_sop;
        out_eop_q   <= acc1 ? bus.in1_eop  : bus.in0_eop;
        out_data_q  <= acc1 ? bus.in1_data : bus.in0_data;
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
        out_channel_q <= acc1;
`endif
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Packet lock: any beat starts a packet in IDLE (sop is not required);
      // a single-beat packet (eop on the first beat) never takes the lock.
      case (state)
        IDLE: begin
          if (acc0) begin
            last_grant <= 1'b0;
            if (!bus.in0_eop) begin
              state <= LOCK0;
            end
          end else if (acc1) begin
            last_grant <= 1'b1;
            if (!bus.in1_eop) begin
              state <= LOCK1;
            end
          end
        end
        LOCK0: begin
          if (acc0 && bus.in0_eop) begin
            state <= IDLE;
          end
        end
        LOCK1: begin
          if (acc1 && bus.in1_eop) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_sys_st_byte_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_sys_st_byte_arbiter
// Purpose  : Self-checking bench for ddr2_sys_st_byte_arbiter. Directed
//            packets are queued per requester; a packet-level model (who owns
//            the bus, who was granted last, what beat sits in the output
//            register) predicts readies and outputs every cycle, and the
//            observed output stream is compared with hand-written sequences.
// Options  : DDR2_SYS_ST_ARB_CHANNEL_EN enables out_channel checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr2_sys_st_byte_arbiter;

  localparam int DATA_W   = 8;
  localparam int RR_FIRST = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_sys_st_byte_arbiter_if #(.DATA_W(DATA_W)) bus ();

  ddr2_sys_st_byte_arbiter #(
    .DATA_W   (DATA_W),
    .RR_FIRST (RR_FIRST)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       ch;
  } obs_t;

  beat_t q0[$];
  beat_t q1[$];
  obs_t  log_q[$];

  int checks = 0;
  int errors = 0;

  // Packet-level model
  int         m_owner;   // -1 = no lock, else requester holding the packet
  int         m_last;    // requester granted most recently
  logic       m_mv;
  logic [7:0] m_d;
  logic       m_sop;
  logic       m_eop;
  logic       m_ch;

  logic       t0, t1;
  int         busy_cnt, hold_cnt, stall_left;
  logic       stall_arm, rst_arm, rst_release;
  logic [7:0] stall_val, rst_val;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input int idx, input logic [7:0] d, input logic sop, input logic eop);
    if (idx < log_q.size()) begin
      chk8("log_data", log_q[idx].d, d);
      chk1("log_sop", log_q[idx].sop, sop);
      chk1("log_eop", log_q[idx].eop, eop);
    end else begin
      chk1("log_missing_beat", 1'b0, 1'b1);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = (RR_FIRST == 0) ? 1 : 0;
    m_mv    = 1'b0;
    m_d     = 8'h00;
    m_sop   = 1'b0;
    m_eop   = 1'b0;
    m_ch    = 1'b0;
  endtask

  task automatic drive();
    bus.in0_valid = (q0.size() > 0);
    bus.in0_data  = (q0.size() > 0) ? q0[0].d   : 8'h00;
    bus.in0_sop   = (q0.size() > 0) ? q0[0].sop : 1'b0;
    bus.in0_eop   = (q0.size() > 0) ? q0[0].eop : 1'b0;
    bus.in1_valid = (q1.size() > 0);
    bus.in1_data  = (q1.size() > 0) ? q1[0].d   : 8'h00;
    bus.in1_sop   = (q1.size() > 0) ? q1[0].sop : 1'b0;
    bus.in1_eop   = (q1.size() > 0) ? q1[0].eop : 1'b0;
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic sop, input logic eop);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop;
    if (src == 0) q0.push_back(b);
    else          q1.push_back(b);
    drive();
  endtask

  // Per-cycle comparison against the model, then advance the model over the
  // coming rising edge using the inputs that will be sampled there.
  task automatic compare_cycle();
    int         cand;
    logic       can_load;
    logic       v;
    obs_t       o;
    t0 = 1'b0;
    t1 = 1'b0;
    if (!reset_n) begin
      chk1("rst_in0_ready", bus.in0_ready, 1'b0);
      chk1("rst_in1_ready", bus.in1_ready, 1'b0);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      model_reset();
      return;
    end
    can_load = !m_mv || bus.out_ready;
    if (m_owner >= 0)                      cand = m_owner;
    else if (bus.in0_valid && bus.in1_valid) cand = 1 - m_last;
    else if (bus.in0_valid)                cand = 0;
    else if (bus.in1_valid)                cand = 1;
    else                                   cand = -1;

    chk1("in0_ready", bus.in0_ready, can_load && (cand == 0));
    chk1("in1_ready", bus.in1_ready, can_load && (cand == 1));
    chk1("out_valid", bus.out_valid, m_mv);
    chk1("busy", bus.busy, m_owner >= 0);
    if (m_mv) begin
      chk8("out_data", bus.out_data, m_d);
      chk1("out_sop", bus.out_sop, m_sop);
      chk1("out_eop", bus.out_eop, m_eop);
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
      chk1("out_channel", bus.out_channel, m_ch);
`endif
    end

    if (bus.busy) busy_cnt++;
    if (bus.out_valid && !bus.out_ready && !bus.in0_ready && !bus.in1_ready &&
        bus.out_data == 8'h22) hold_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      o.d = bus.out_data; o.sop = bus.out_sop; o.eop = bus.out_eop;
`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
      o.ch = bus.out_channel;
`else
      o.ch = 1'b0;
`endif
      log_q.push_back(o);
    end
    t0 = bus.in0_valid && bus.in0_ready;
    t1 = bus.in1_valid && bus.in1_ready;

    v = (cand == 0) ? bus.in0_valid : ((cand == 1) ? bus.in1_valid : 1'b0);
    if (cand >= 0 && can_load && v) begin
      m_d   = (cand == 0) ? bus.in0_data : bus.in1_data;
      m_sop = (cand == 0) ? bus.in0_sop  : bus.in1_sop;
      m_eop = (cand == 0) ? bus.in0_eop  : bus.in1_eop;
      m_ch  = (cand == 1);
      m_mv  = 1'b1;
      if (m_owner < 0) m_last = cand;
      m_owner = m_eop ? -1 : cand;
    end else if (bus.out_ready) begin
      m_mv = 1'b0;
    end
  endtask

  // One clock cycle: optional stall/reset injection at the falling edge,
  // comparison, then input update just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (reset_n && stall_arm && bus.out_valid && bus.out_data == stall_val) begin
      stall_arm  = 1'b0;
      bus.out_ready = 1'b0;
      stall_left = 4;
    end
    if (reset_n && rst_arm && bus.out_valid && bus.out_data == rst_val) begin
      rst_arm = 1'b0;
      reset_n = 1'b0;
      q0.delete();
      q1.delete();
      drive();
      log_q.delete();
      #1;
      chk1("midrst_out_valid", bus.out_valid, 1'b0);
      chk1("midrst_busy", bus.busy, 1'b0);
      chk1("midrst_in0_ready", bus.in0_ready, 1'b0);
      rst_release = 1'b1;
    end
    #1;
    compare_cycle();
    @(posedge clk);
    #1;
    if (rst_release) begin
      reset_n = 1'b1;
      rst_release = 1'b0;
    end
    if (t0 && q0.size() > 0) void'(q0.pop_front());
    if (t1 && q1.size() > 0) void'(q1.pop_front());
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) bus.out_ready = 1'b1;
    end
    drive();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk1("wait_log_timeout", log_q.size() >= n, 1'b1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    step();
    reset_n = 1'b1;
    step();
    log_q.delete();
  endtask

  initial begin
    int k;
    stall_arm = 1'b0; rst_arm = 1'b0; rst_release = 1'b0;
    stall_left = 0; busy_cnt = 0; hold_cnt = 0;
    stall_val = 8'h00; rst_val = 8'h00;
    t0 = 1'b0; t1 = 1'b0;
    model_reset();
    bus.out_ready = 1'b1;

    // Reset state with both requesters asserting valid
    reset_n = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_data = 8'h77; bus.in0_sop = 1'b1; bus.in0_eop = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h88; bus.in1_sop = 1'b1; bus.in1_eop = 1'b0;
    #1;
    chk1("reset_in0_ready", bus.in0_ready, 1'b0);
    chk1("reset_in1_ready", bus.in1_ready, 1'b0);
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_busy", bus.busy, 1'b0);
    chk8("reset_out_data", bus.out_data, 8'h00);
    drive();
    step();
    step();
    reset_n = 1'b1;
    step();

    // Three-beat packet on requester 0
    busy_cnt = 0;
    log_q.delete();
    push(0, 8'h11, 1'b1, 1'b0);
    push(0, 8'h22, 1'b0, 1'b0);
    push(0, 8'h33, 1'b0, 1'b1);
    wait_log(3, 20);
    step(); step();
    chk_log(0, 8'h11, 1'b1, 1'b0);
    chk_log(1, 8'h22, 1'b0, 1'b0);
    chk_log(2, 8'h33, 1'b0, 1'b1);
    chk8("busy_cycles", 8'(busy_cnt), 8'd2);

    // Tie after reset: in0 first, then the repeated tie goes to in1
    apply_reset();
    push(0, 8'hA0, 1'b1, 1'b0);
    push(0, 8'hA1, 1'b0, 1'b1);
    push(0, 8'hA2, 1'b1, 1'b0);
    push(0, 8'hA3, 1'b0, 1'b1);
    push(1, 8'hB0, 1'b1, 1'b0);
    push(1, 8'hB1, 1'b0, 1'b1);
    wait_log(6, 40);
    step(); step();
    chk_log(0, 8'hA0, 1'b1, 1'b0);
    chk_log(1, 8'hA1, 1'b0, 1'b1);
    chk_log(2, 8'hB0, 1'b1, 1'b0);
    chk_log(3, 8'hB1, 1'b0, 1'b1);
    chk_log(4, 8'hA2, 1'b1, 1'b0);
    chk_log(5, 8'hA3, 1'b0, 1'b1);

    // in1 holds the lock while in0 requests mid-packet
    log_q.delete();
    push(1, 8'hC0, 1'b1, 1'b0);
    push(1, 8'hC1, 1'b0, 1'b0);
    push(1, 8'hC2, 1'b0, 1'b0);
    push(1, 8'hC3, 1'b0, 1'b1);
    step(); step();
    push(0, 8'hD0, 1'b1, 1'b1);
    wait_log(5, 40);
    step(); step();
    chk_log(0, 8'hC0, 1'b1, 1'b0);
    chk_log(3, 8'hC3, 1'b0, 1'b1);
    chk_log(4, 8'hD0, 1'b1, 1'b1);

    // Downstream stall for four cycles while 0x22 sits in the output
    log_q.delete();
    hold_cnt = 0;
    stall_val = 8'h22;
    stall_arm = 1'b1;
    push(0, 8'h11, 1'b1, 1'b0);
    push(0, 8'h22, 1'b0, 1'b0);
    push(0, 8'h33, 1'b0, 1'b1);
    wait_log(3, 40);
    step(); step(); step();
    chk8("stall_hold_cycles", 8'(hold_cnt), 8'd4);
    chk8("stall_beat_count", 8'(log_q.size()), 8'd3);
    chk_log(0, 8'h11, 1'b1, 1'b0);
    chk_log(1, 8'h22, 1'b0, 1'b0);
    chk_log(2, 8'h33, 1'b0, 1'b1);

    // Reset pulse during beat 2 of a four-beat packet
    log_q.delete();
    rst_val = 8'h42;
    rst_arm = 1'b1;
    push(0, 8'h41, 1'b1, 1'b0);
    push(0, 8'h42, 1'b0, 1'b0);
    push(0, 8'h43, 1'b0, 1'b0);
    push(0, 8'h44, 1'b0, 1'b1);
    k = 0;
    while ((rst_arm || rst_release || !reset_n) && k < 20) begin
      step();
      k++;
    end
    chk1("midrst_seen", rst_arm, 1'b0);
    step();
    log_q.delete();
    push(0, 8'h51, 1'b1, 1'b0);
    push(0, 8'h52, 1'b0, 1'b1);
    wait_log(2, 20);
    step(); step();
    chk8("post_rst_beat_count", 8'(log_q.size()), 8'd2);
    chk_log(0, 8'h51, 1'b1, 1'b0);
    chk_log(1, 8'h52, 1'b0, 1'b1);

`ifdef DDR2_SYS_ST_ARB_CHANNEL_EN
    // Alternating single-beat packets: channel follows the source
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      push(i % 2, (i % 2 == 1) ? 8'h5A : 8'hA5, 1'b1, 1'b1);
      wait_log(i + 1, 20);
    end
    step(); step();
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        chk1("chan_idx", log_q[i].ch, (i % 2 == 1));
        chk8("chan_data", log_q[i].d, (i % 2 == 1) ? 8'h5A : 8'hA5);
      end else begin
        chk1("chan_missing_beat", 1'b0, 1'b1);
      end
    end
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
